// File: rtl/adc_pkg.sv
// Shared types and constants for the single-slope ADC back end.
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRESET = 2'd1,
      RAMP   = 2'd2,
      DONE   = 2'd3
   } ramp_state_t;

   localparam int DEFAULT_WIDTH   = 8;
   localparam int CMP_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchronizer, async active-low reset to 0; only compiled when RAMP_ADC_CMP_SYNC_EN
// is defined, so the default build carries no synchronizer flops. Latency 2 cycles, no backpressure.
`ifdef RAMP_ADC_CMP_SYNC_EN
module sync_2ff
   import adc_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [CMP_SYNC_STAGES-1:0][W-1:0] stg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg <= '0;
      end else begin
         stg <= {stg[CMP_SYNC_STAGES-2:0], d};
      end
   end

   assign q = stg[CMP_SYNC_STAGES-1];

endmodule
`endif

// File: rtl/ramp_adc_ctrl.sv
// Single-slope ADC conversion sequencer (counter initiator); optional cmp synchronizer via RAMP_ADC_CMP_SYNC_EN.
// Latency start->done = SETTLE_CYCLES + (code-OFFSET) + 2 (+2 with sync); start ignored while busy, no queueing.
module ramp_adc_ctrl
   import adc_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int SETTLE_CYCLES = 4,
   parameter int OFFSET        = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp,
   input  logic [WIDTH-1:0] count,
   input  logic             overflow,
   output logic             ctr_en,
   output logic             ctr_set,
   output logic [WIDTH-1:0] ctr_set_v,
   output logic             ramp_en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ovf_err
);

   localparam logic [WIDTH-1:0] OFF_V = WIDTH'(OFFSET);
   localparam logic [WIDTH-1:0] MAX_V = '1;
   localparam int               SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   ramp_state_t      state;
   logic [SW-1:0]    settle_cnt;
   logic             trip;
   logic [WIDTH-1:0] trip_code;

`ifdef RAMP_ADC_CMP_SYNC_EN
   logic cmp_s;

   sync_2ff #(.W(1)) u_cmp_sync (
      .clk   (clk),
      .rst_n (rst),
      .d     (cmp),
      .q     (cmp_s)
   );

   // The synchronized trip lands two counts late; back that out, never below the preset.
   assign trip      = cmp_s;
   assign trip_code = ({1'b0, count} >= ({1'b0, OFF_V} + (WIDTH+1)'(2))) ? count - WIDTH'(2) : OFF_V;
`else
   assign trip      = cmp;
   assign trip_code = count;
`endif

   assign ctr_set_v = OFF_V;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         ctr_en     <= 1'b0;
         ctr_set    <= 1'b0;
         ramp_en    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         ovf_err    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state      <= PRESET;
                  settle_cnt <= SETTLE_LAST;
                  ctr_set    <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            PRESET: begin
               if (settle_cnt == '0) begin
                  state   <= RAMP;
                  ctr_set <= 1'b0;
                  ctr_en  <= 1'b1;
                  ramp_en <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt - SW'(1);
               end
            end
            RAMP: begin
               // Overflow takes priority over a trip in the same cycle.
               if (overflow || trip) begin
                  state   <= DONE;
                  ctr_en  <= 1'b0;
                  ramp_en <= 1'b0;
                  done    <= 1'b1;
                  result  <= overflow ? MAX_V : trip_code;
                  ovf_err <= overflow;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
